rc4_prga_decrypt: RTL and testbench

- RC4 pseudo-random generation and decrypt stage, directly downstream of the key-schedule FSM.
- On `start`, consumes the scheduled S array in s_memory and reads ciphertext bytes from the encrypted-message ROM.
- Continues swapping S, XORs each keystream byte with the ciphertext and writes plaintext to the decrypted-message RAM.
- `done` hands control back to the top-level memory mux and brute-force controller.

---
 rtl/rc4_pkg.sv | 27 ++
 rtl/rc4_prga_decrypt_if.sv | 34 +++
 rtl/rc4_ascii_check.sv | 9 +
 rtl/rc4_prga_decrypt.sv | 183 ++++++++++++++++++
 tb/tb_rc4_prga_decrypt.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA/decrypt stage.
// PRGA_ASCII_CHECK_EN selects the plaintext ASCII filter in rc4_prga_decrypt.
package rc4_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_I,
      ST_WT_I,
      ST_RD_J,
      ST_WT_J,
      ST_SW_I,
      ST_SW_J,
      ST_RD_F,
      ST_WT_F,
      ST_WR_D,
      ST_NEXT,
      ST_DONE
   } prga_state_t;

   localparam logic [7:0] ASCII_LO    = 8'h61;
   localparam logic [7:0] ASCII_HI    = 8'h7A;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   localparam int MSG_LEN_DEFAULT = 32;
   localparam int MSG_AW          = 5;

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// Control handshake plus S-memory, ciphertext ROM and plaintext RAM ports
// of the RC4 PRGA/decrypt stage.
interface rc4_prga_decrypt_if
   import rc4_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              start;
   logic              busy;
   logic              done;
   logic              key_invalid;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;
   logic              s_wren;
   logic [DATA_W-1:0] s_rdata;
   logic [MSG_AW-1:0] rom_addr;
   logic [DATA_W-1:0] rom_rdata;
   logic [MSG_AW-1:0] dec_addr;
   logic [DATA_W-1:0] dec_wdata;
   logic              dec_wren;

   modport master (
      input  start, s_rdata, rom_rdata,
      output busy, done, key_invalid, s_addr, s_wdata, s_wren,
             rom_addr, dec_addr, dec_wdata, dec_wren
   );

   modport slave (
      output start, s_rdata, rom_rdata,
      input  busy, done, key_invalid, s_addr, s_wdata, s_wren,
             rom_addr, dec_addr, dec_wdata, dec_wren
   );
endinterface

// File: rtl/rc4_ascii_check.sv
// Flags a plaintext byte as plausible: lowercase letter or space.
module rc4_ascii_check
   import rc4_pkg::*;
(
   input  logic [7:0] data,
   output logic       valid
);
   assign valid = ((data >= ASCII_LO) && (data <= ASCII_HI)) || (data == ASCII_SPACE);
endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generation and decrypt, 10 cycles per message byte.
// Define PRGA_ASCII_CHECK_EN to abort on the first non-lowercase/space plaintext byte.
module rc4_prga_decrypt
   import rc4_pkg::*;
#(
   parameter int MSG_LEN = MSG_LEN_DEFAULT,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   rc4_prga_decrypt_if.master bus
);
   localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

   prga_state_t       state_reg, state_next;
   logic [ADDR_W-1:0] i_reg, i_next, j_reg, j_next;
   logic [7:0]        k_reg, k_next;
   logic [DATA_W-1:0] si_reg, si_next, sj_reg, sj_next;
   logic [ADDR_W-1:0] s_addr_reg, s_addr_next;
   logic [DATA_W-1:0] s_wdata_reg, s_wdata_next;
   logic              s_wren_reg, s_wren_next;
   logic [MSG_AW-1:0] rom_addr_reg, rom_addr_next;
   logic [MSG_AW-1:0] dec_addr_reg, dec_addr_next;
   logic [DATA_W-1:0] dec_wdata_reg, dec_wdata_next;
   logic              dec_wren_reg, dec_wren_next;
   logic [DATA_W-1:0] plain;

   assign plain = bus.s_rdata ^ bus.rom_rdata;

`ifdef PRGA_ASCII_CHECK_EN
   logic key_invalid_reg, key_invalid_next;
   logic byte_ok;

   rc4_ascii_check u_ascii_check (
      .data  (plain[7:0]),
      .valid (byte_ok)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) key_invalid_reg <= 1'b0;
      else          key_invalid_reg <= key_invalid_next;
   end

   assign bus.key_invalid = key_invalid_reg;
`else
   assign bus.key_invalid = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= ST_IDLE;
         i_reg         <= '0;
         j_reg         <= '0;
         k_reg         <= '0;
         si_reg        <= '0;
         sj_reg        <= '0;
         s_addr_reg    <= '0;
         s_wdata_reg   <= '0;
         s_wren_reg    <= 1'b0;
         rom_addr_reg  <= '0;
         dec_addr_reg  <= '0;
         dec_wdata_reg <= '0;
         dec_wren_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         i_reg         <= i_next;
         j_reg         <= j_next;
         k_reg         <= k_next;
         si_reg        <= si_next;
         sj_reg        <= sj_next;
         s_addr_reg    <= s_addr_next;
         s_wdata_reg   <= s_wdata_next;
         s_wren_reg    <= s_wren_next;
         rom_addr_reg  <= rom_addr_next;
         dec_addr_reg  <= dec_addr_next;
         dec_wdata_reg <= dec_wdata_next;
         dec_wren_reg  <= dec_wren_next;
      end
   end

   // Each state's assignments land in the registers at its closing edge, so
   // an address set in RD_x is on the bus during WT_x and its data is read next.
   always_comb begin
      state_next     = state_reg;
      i_next         = i_reg;
      j_next         = j_reg;
      k_next         = k_reg;
      si_next        = si_reg;
      sj_next        = sj_reg;
      s_addr_next    = s_addr_reg;
      s_wdata_next   = s_wdata_reg;
      s_wren_next    = 1'b0;
      rom_addr_next  = rom_addr_reg;
      dec_addr_next  = dec_addr_reg;
      dec_wdata_next = dec_wdata_reg;
      dec_wren_next  = 1'b0;
`ifdef PRGA_ASCII_CHECK_EN
      key_invalid_next = key_invalid_reg;
`endif
      case (state_reg)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               i_next     = ADDR_W'(1);
               j_next     = '0;
               k_next     = '0;
               state_next = ST_RD_I;
`ifdef PRGA_ASCII_CHECK_EN
               key_invalid_next = 1'b0;
`endif
            end
         end
         ST_RD_I: begin
            s_addr_next = i_reg;
            state_next  = ST_WT_I;
         end
         ST_WT_I: state_next = ST_RD_J;
         ST_RD_J: begin
            si_next     = bus.s_rdata;
            j_next      = j_reg + ADDR_W'(bus.s_rdata);
            s_addr_next = j_reg + ADDR_W'(bus.s_rdata);
            state_next  = ST_WT_J;
         end
         ST_WT_J: state_next = ST_SW_I;
         ST_SW_I: begin
            sj_next      = bus.s_rdata;
            s_addr_next  = i_reg;
            s_wdata_next = bus.s_rdata;
            s_wren_next  = 1'b1;
            state_next   = ST_SW_J;
         end
         ST_SW_J: begin
            s_addr_next  = j_reg;
            s_wdata_next = si_reg;
            s_wren_next  = 1'b1;
            state_next   = ST_RD_F;
         end
         ST_RD_F: begin
            s_addr_next   = ADDR_W'(si_reg + sj_reg);
            rom_addr_next = k_reg[MSG_AW-1:0];
            state_next    = ST_WT_F;
         end
         ST_WT_F: state_next = ST_WR_D;
         ST_WR_D: begin
            dec_addr_next  = k_reg[MSG_AW-1:0];
            dec_wdata_next = plain;
`ifdef PRGA_ASCII_CHECK_EN
            if (!byte_ok) begin
               key_invalid_next = 1'b1;
               state_next       = ST_DONE;
            end else begin
               dec_wren_next = 1'b1;
               state_next    = ST_NEXT;
            end
`else
            dec_wren_next = 1'b1;
            state_next    = ST_NEXT;
`endif
         end
         ST_NEXT: begin
            if (k_reg == K_LAST) begin
               state_next = ST_DONE;
            end else begin
               k_next     = k_reg + 8'd1;
               i_next     = i_reg + ADDR_W'(1);
               state_next = ST_RD_I;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign bus.busy      = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
   assign bus.done      = (state_reg == ST_DONE);
   assign bus.s_addr    = s_addr_reg;
   assign bus.s_wdata   = s_wdata_reg;
   assign bus.s_wren    = s_wren_reg;
   assign bus.rom_addr  = rom_addr_reg;
   assign bus.dec_addr  = dec_addr_reg;
   assign bus.dec_wdata = dec_wdata_reg;
   assign bus.dec_wren  = dec_wren_reg;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt with behavioural S memory, ROM and RAM.
// Built with PRGA_ASCII_CHECK_EN it exercises the ASCII abort path instead.
module tb_rc4_prga_decrypt;
   import rc4_pkg::*;

   localparam int N       = 32;
   localparam int MAX_CYC = 400;

   logic clk;
   logic reset_n;

   rc4_prga_decrypt_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   rc4_prga_decrypt #(.MSG_LEN(N), .ADDR_W(8), .DATA_W(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   logic [7:0] s_mem   [256];
   logic [7:0] rom_mem [N];
   logic [7:0] dec_mem [N];
   logic [7:0] ks      [N];
   logic [7:0] snap2, snap3;

   int   n_checks = 0;
   int   n_errors = 0;
   int   busy_cnt, s_wr_cnt, dec_wr_cnt;
   logic mon_en = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous memories: registered read, read-before-write
   always @(posedge clk) begin
      bus.s_rdata   <= s_mem[bus.s_addr];
      bus.rom_rdata <= rom_mem[bus.rom_addr];
      if (bus.s_wren)   s_mem[bus.s_addr]     = bus.s_wdata;
      if (bus.dec_wren) dec_mem[bus.dec_addr] = bus.dec_wdata;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.busy)     busy_cnt++;
         if (bus.s_wren)   s_wr_cnt++;
         if (bus.dec_wren) dec_wr_cnt++;
      end
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic load_identity();
      for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
   endtask

   task automatic load_ksa(input logic [23:0] key);
      logic [7:0] kb [3];
      logic [7:0] j, t;
      kb[0] = key[23:16];
      kb[1] = key[15:8];
      kb[2] = key[7:0];
      for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
      j = 8'd0;
      for (int x = 0; x < 256; x++) begin
         j = j + s_mem[x] + kb[x % 3];
         t = s_mem[x];
         s_mem[x] = s_mem[j];
         s_mem[j] = t;
      end
   endtask

   // Software RC4 PRGA over a copy of the current S memory
   task automatic model_prga();
      logic [7:0] s [256];
      logic [7:0] i, j, t;
      for (int x = 0; x < 256; x++) s[x] = s_mem[x];
      i = 8'd0;
      j = 8'd0;
      for (int k = 0; k < N; k++) begin
         i = i + 8'd1;
         j = j + s[i];
         t = s[i];
         s[i] = s[j];
         s[j] = t;
         t = s[i] + s[j];
         ks[k] = s[t];
      end
   endtask

   task automatic clear_dec();
      for (int k = 0; k < N; k++) dec_mem[k] = 8'h00;
   endtask

   task automatic run_msg(input string tag, input int mid_cyc,
                          output int done_cyc, output logic d1, output logic ki1);
      int cyc;
      done_cyc   = -1;
      d1         = 1'bx;
      ki1        = 1'bx;
      busy_cnt   = 0;
      s_wr_cnt   = 0;
      dec_wr_cnt = 0;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      mon_en = 1'b1;
      cyc = 1;
      while (cyc <= MAX_CYC && done_cyc < 0) begin
         @(negedge clk);
         if (cyc == 1) begin
            d1  = bus.done;
            ki1 = bus.key_invalid;
         end
         if (cyc == 20) begin
            snap2 = s_mem[2];
            snap3 = s_mem[3];
         end
         if (bus.done) begin
            done_cyc = cyc;
         end else begin
            bus.start = (cyc == mid_cyc);
            @(posedge clk);
            #1 bus.start = 1'b0;
            cyc++;
         end
      end
      mon_en = 1'b0;
      $display("run %s: done at cycle %0d, busy %0d, s writes %0d, dec writes %0d",
               tag, done_cyc, busy_cnt, s_wr_cnt, dec_wr_cnt);
   endtask

   int   done_cyc;
   logic d1, ki1;

   initial begin
      reset_n   = 1'b0;
      bus.start = 1'b0;
      load_identity();
      for (int k = 0; k < N; k++) rom_mem[k] = 8'h00;
      clear_dec();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_value("rst_busy",        bus.busy,        1'b0);
      check_value("rst_done",        bus.done,        1'b0);
      check_value("rst_s_wren",      bus.s_wren,      1'b0);
      check_value("rst_dec_wren",    bus.dec_wren,    1'b0);
      check_value("rst_key_invalid", bus.key_invalid, 1'b0);
      check_value("rst_s_addr",      bus.s_addr,      8'h00);
      reset_n = 1'b1;

`ifdef PRGA_ASCII_CHECK_EN
      // All-lowercase plaintext runs to completion
      load_identity();
      model_prga();
      for (int k = 0; k < N; k++) rom_mem[k] = ks[k] ^ (8'h61 + 8'(k % 26));
      clear_dec();
      run_msg("ascii_ok", 0, done_cyc, d1, ki1);
      check_value("ok_done_cyc", done_cyc, 321);
      check_value("ok_dec_wr",   dec_wr_cnt, 32);
      check_value("ok_key_inv",  bus.key_invalid, 1'b0);
      for (int k = 0; k < N; k++)
         check_value($sformatf("ok_dec%0d", k), dec_mem[k], 8'h61 + 8'(k % 26));

      // 0x9C at k=0 aborts without writing
      load_identity();
      model_prga();
      rom_mem[0] = ks[0] ^ 8'h9C;
      clear_dec();
      run_msg("ascii_bad", 0, done_cyc, d1, ki1);
      check_value("bad_done_cyc", done_cyc, 10);
      check_value("bad_dec_wr",   dec_wr_cnt, 0);
      check_value("bad_key_inv",  bus.key_invalid, 1'b1);
      check_value("bad_dec0",     dec_mem[0], 8'h00);

      // Next start clears key_invalid
      load_identity();
      rom_mem[0] = ks[0] ^ 8'h61;
      run_msg("ascii_retry", 0, done_cyc, d1, ki1);
      check_value("retry_ki_cyc1", ki1, 1'b0);
      check_value("retry_done_cyc", done_cyc, 321);
      check_value("retry_key_inv", bus.key_invalid, 1'b0);
`else
      // Identity S: keystream 0x02, 0x05 for the first two bytes
      load_identity();
      for (int k = 0; k < N; k++) rom_mem[k] = 8'h00;
      rom_mem[0] = 8'h41;
      rom_mem[1] = 8'h60;
      clear_dec();
      run_msg("identity", 0, done_cyc, d1, ki1);
      check_value("id_done_cyc", done_cyc, 321);
      check_value("id_busy_cnt", busy_cnt, 320);
      check_value("id_s_wr",     s_wr_cnt, 64);
      check_value("id_dec_wr",   dec_wr_cnt, 32);
      check_value("id_dec0",     dec_mem[0], 8'h43);
      check_value("id_dec1",     dec_mem[1], 8'h65);
      check_value("id_s2",       snap2, 8'h03);
      check_value("id_s3",       snap3, 8'h02);
      check_value("id_key_inv",  bus.key_invalid, 1'b0);

      // Reference key 0x000249 against a software RC4 model
      load_ksa(24'h000249);
      model_prga();
      for (int k = 0; k < N; k++) rom_mem[k] = 8'(k * 29 + 7);
      clear_dec();
      run_msg("key_000249", 0, done_cyc, d1, ki1);
      check_value("ref_done_cyc", done_cyc, 321);
      for (int k = 0; k < N; k++)
         check_value($sformatf("ref_dec%0d", k), dec_mem[k], rom_mem[k] ^ ks[k]);

      // Non-ASCII byte is written normally
      load_identity();
      model_prga();
      rom_mem[0] = ks[0] ^ 8'h9C;
      clear_dec();
      run_msg("non_ascii", 0, done_cyc, d1, ki1);
      check_value("na_dec0",    dec_mem[0], 8'h9C);
      check_value("na_dec_wr",  dec_wr_cnt, 32);
      check_value("na_key_inv", bus.key_invalid, 1'b0);

      // start at byte 10 is ignored
      load_identity();
      model_prga();
      clear_dec();
      run_msg("mid_start", 103, done_cyc, d1, ki1);
      check_value("mid_done_cyc", done_cyc, 321);
      check_value("mid_dec_wr",   dec_wr_cnt, 32);
      for (int k = 0; k < N; k++)
         check_value($sformatf("mid_dec%0d", k), dec_mem[k], rom_mem[k] ^ ks[k]);

      // start from DONE gives an identical rerun
      load_identity();
      clear_dec();
      run_msg("rerun", 0, done_cyc, d1, ki1);
      check_value("rerun_done_cyc1", d1, 1'b0);
      check_value("rerun_done_cyc",  done_cyc, 321);
      for (int k = 0; k < N; k++)
         check_value($sformatf("rerun_dec%0d", k), dec_mem[k], rom_mem[k] ^ ks[k]);
`endif

      // Reset during WT_J of byte 5 (cycle 54)
      load_identity();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (53) @(posedge clk);
      @(negedge clk);
      check_value("abort_busy_before", bus.busy, 1'b1);
      reset_n = 1'b0;
      #1;
      check_value("abort_s_wren",   bus.s_wren,   1'b0);
      check_value("abort_dec_wren", bus.dec_wren, 1'b0);
      check_value("abort_busy",     bus.busy,     1'b0);
      check_value("abort_done",     bus.done,     1'b0);
      check_value("abort_s_addr",   bus.s_addr,   8'h00);
      check_value("abort_dec_addr", bus.dec_addr, 5'h00);
      repeat (2) @(negedge clk);
      reset_n    = 1'b1;
      busy_cnt   = 0;
      s_wr_cnt   = 0;
      dec_wr_cnt = 0;
      mon_en     = 1'b1;
      repeat (30) @(negedge clk);
      mon_en = 1'b0;
      $display("run abort: idle window busy %0d, s writes %0d, dec writes %0d",
               busy_cnt, s_wr_cnt, dec_wr_cnt);
      check_value("abort_idle_busy",  busy_cnt,   0);
      check_value("abort_idle_s_wr",  s_wr_cnt,   0);
      check_value("abort_idle_dec_wr", dec_wr_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
